game_sequencer: RTL and testbench

Phase sequencer for the bomb-dismantlement game. It owns the game state machine: power-up, code reveal, timed code entry, win/lose display and automatic re-arm. It generates its own 5-bit pseudo-random code and its 1-second time base, and drives the enable lines of the display, countdown, keypad-verify and face modules. It sits between the board switches/buttons and those display and datapath blocks.

---
 rtl/game_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: phase sequencer for the bomb-dismantlement game.
// Owns the game FSM (OFF/IDLE/SHOW/INPUT/WIN/LOSE), the secret-code LFSR,
// the one-second prescaler and the registered enables for the display,
// countdown, keypad-verify and face blocks.
module game_sequencer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int SHOW_SEC    = 3,
  parameter int TIMEOUT_SEC = 20,
  parameter int RESULT_SEC  = 3,
  parameter int MAX_TRIES   = 3
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       en,
  input  logic       start_btn,
  input  logic       code_valid,
  input  logic [4:0] code_in,
  output logic       bomb_on,
  output logic       show_en,
  output logic [4:0] code_out,
  output logic       count_en,
  output logic [6:0] sec_left,
  output logic       input_en,
  output logic [1:0] tries_left,
  output logic       wrong,
  output logic       success,
  output logic       fail,
  output logic       rearm
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_OFF, S_IDLE, S_SHOW, S_INPUT, S_WIN, S_LOSE
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [6:0]    sec_n;
  logic [1:0]    tries_n;
  logic [4:0]    code_n;
  logic          wrong_n, rearm_n;
  logic [4:0]    lfsr;
  logic          start_q;
  logic          tick, start_edge, code_match, last_sec;

  assign tick       = (presc == TICK_LAST);
  assign start_edge = start_btn & ~start_q;
  assign code_match = (code_in == code_out);
  assign last_sec   = (sec_left == 7'd1);

  // Free-running code LFSR (x^5+x^3+1) and start-button edge history;
  // start history resets high so a button held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      lfsr    <= 5'b00001;
      start_q <= 1'b1;
    end else begin
      lfsr    <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      start_q <= start_btn;
    end
  end

  // Next-state and next-datapath decisions; en low overrides everything.
  always_comb begin
    state_n = state;
    presc_n = tick ? '0 : presc + 1'b1;
    sec_n   = sec_left;
    tries_n = tries_left;
    code_n  = code_out;
    wrong_n = 1'b0;
    rearm_n = 1'b0;
    case (state)
      S_OFF: begin
        presc_n = '0;
        sec_n   = '0;
        tries_n = '0;
        code_n  = '0;
        if (en) state_n = S_IDLE;
      end
      S_IDLE: begin
        presc_n = '0;
        sec_n   = '0;
        if (start_edge) begin
          state_n = S_SHOW;
          code_n  = lfsr;
          sec_n   = 7'(SHOW_SEC);
          tries_n = 2'(MAX_TRIES);
        end
      end
      S_SHOW: begin
        if (tick) begin
          if (last_sec) begin
            state_n = S_INPUT;
            presc_n = '0;
            sec_n   = 7'(TIMEOUT_SEC);
          end else begin
            sec_n = sec_left - 7'd1;
          end
        end
      end
      S_INPUT: begin
        // A correct code beats a coincident timeout; a final miss or the
        // timeout both lose without a wrong pulse.
        if (code_valid && code_match) begin
          state_n = S_WIN;
          presc_n = '0;
          sec_n   = 7'(RESULT_SEC);
        end else if ((code_valid && tries_left == 2'd1) || (tick && last_sec)) begin
          state_n = S_LOSE;
          presc_n = '0;
          sec_n   = 7'(RESULT_SEC);
        end else begin
          if (tick) sec_n = sec_left - 7'd1;
          if (code_valid) begin
            tries_n = tries_left - 2'd1;
            wrong_n = 1'b1;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (tick) begin
          if (last_sec) begin
            state_n = S_IDLE;
            presc_n = '0;
            sec_n   = '0;
            rearm_n = 1'b1;
          end else begin
            sec_n = sec_left - 7'd1;
          end
        end
      end
      default: state_n = S_OFF;
    endcase
    if (!en) begin
      state_n = S_OFF;
      presc_n = '0;
      sec_n   = '0;
      tries_n = '0;
      code_n  = '0;
      wrong_n = 1'b0;
      rearm_n = 1'b0;
    end
  end

  // FSM state and registered outputs, decoded from the next state so each
  // output is valid in the first cycle the state is held.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state      <= S_OFF;
      presc      <= '0;
      sec_left   <= '0;
      tries_left <= '0;
      code_out   <= '0;
      wrong      <= 1'b0;
      rearm      <= 1'b0;
      bomb_on    <= 1'b0;
      show_en    <= 1'b0;
      count_en   <= 1'b0;
      input_en   <= 1'b0;
      success    <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= state_n;
      presc      <= presc_n;
      sec_left   <= sec_n;
      tries_left <= tries_n;
      code_out   <= code_n;
      wrong      <= wrong_n;
      rearm      <= rearm_n;
      bomb_on    <= (state_n == S_IDLE) || (state_n == S_SHOW) ||
                    (state_n == S_INPUT) || (state_n == S_LOSE);
      show_en    <= (state_n == S_SHOW);
      count_en   <= (state_n == S_INPUT);
      input_en   <= (state_n == S_INPUT);
      success    <= (state_n == S_WIN);
      fail       <= (state_n == S_LOSE);
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer with small timing parameters.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       Rst = 1'b0;
  logic       en = 1'b0;
  logic       start_btn = 1'b1;
  logic       code_valid = 1'b0;
  logic [4:0] code_in = '0;
  logic       bomb_on, show_en, count_en, input_en, wrong, success, fail, rearm;
  logic [4:0] code_out;
  logic [6:0] sec_left;
  logic [1:0] tries_left;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] lfsr_m;
  logic [4:0] exp_code;
  logic [4:0] lfsr_first;

  // enable vector: {bomb_on, show_en, count_en, input_en, success, fail}
  localparam int V_OFF   = 6'b000000;
  localparam int V_IDLE  = 6'b100000;
  localparam int V_SHOW  = 6'b110000;
  localparam int V_INPUT = 6'b101100;
  localparam int V_WIN   = 6'b000010;
  localparam int V_LOSE  = 6'b100001;

  game_sequencer #(
    .TICK_DIV(4), .SHOW_SEC(2), .TIMEOUT_SEC(5), .RESULT_SEC(2), .MAX_TRIES(2)
  ) dut (
    .clk(clk), .Rst(Rst), .en(en), .start_btn(start_btn),
    .code_valid(code_valid), .code_in(code_in),
    .bomb_on(bomb_on), .show_en(show_en), .code_out(code_out),
    .count_en(count_en), .sec_left(sec_left), .input_en(input_en),
    .tries_left(tries_left), .wrong(wrong), .success(success),
    .fail(fail), .rearm(rearm)
  );

  always #5 clk = ~clk;

  // reference LFSR x^5+x^3+1, stepping every clock out of reset
  always @(posedge clk) begin
    if (!Rst) lfsr_m <= 5'b00001;
    else      lfsr_m <= {lfsr_m[3:0], lfsr_m[4] ^ lfsr_m[2]};
  end

  function automatic int outs();
    return int'({bomb_on, show_en, count_en, input_en, success, fail});
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // press start and advance until INPUT is entered; returns expected code
  task automatic play_to_input(output logic [4:0] code);
    code = lfsr_m;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    // reset with start held high
    repeat (3) step();
    check("rst_outs", outs(), V_OFF);
    check("rst_code", int'(code_out), 0);
    check("rst_sec", int'(sec_left), 0);
    check("rst_tries", int'(tries_left), 0);
    check("rst_pulses", int'({wrong, rearm}), 0);

    Rst = 1'b1;
    en  = 1'b1;
    step();
    check("idle_outs", outs(), V_IDLE);
    repeat (3) step();
    check("held_start_no_show", outs(), V_IDLE);
    start_btn = 1'b0;
    step();
    check("idle_after_release", outs(), V_IDLE);

    // first game: SHOW window and code latch
    exp_code  = lfsr_m;
    start_btn = 1'b1;
    step();
    check("show_first", outs(), V_SHOW);
    check("show_code", int'(code_out), int'(exp_code));
    check("show_sec", int'(sec_left), 2);
    check("show_tries", int'(tries_left), 2);
    for (int i = 2; i <= 8; i++) begin
      if (i == 3) start_btn = 1'b0;
      step();
      check($sformatf("show_c%0d", i), outs(), V_SHOW);
      check($sformatf("show_sec_c%0d", i), int'(sec_left), (i <= 4) ? 2 : 1);
    end
    // start edge in SHOW is ignored
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("input_entry", outs(), V_INPUT);
    check("input_sec", int'(sec_left), 5);
    check("input_code_held", int'(code_out), int'(exp_code));

    // correct code -> WIN, then rearm
    code_in = exp_code;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check("win_outs", outs(), V_WIN);
    check("win_sec", int'(sec_left), 2);
    for (int i = 0; i < 7; i++) begin
      step();
      check("win_hold", outs(), V_WIN);
      check("win_no_rearm", int'(rearm), 0);
    end
    step();
    check("win_to_idle", outs(), V_IDLE);
    check("win_rearm", int'(rearm), 1);
    step();
    check("rearm_one_cycle", int'(rearm), 0);

    // two wrong entries -> LOSE
    play_to_input(exp_code);
    check("g2_input", outs(), V_INPUT);
    check("g2_code", int'(code_out), int'(exp_code));
    code_in = exp_code ^ 5'h01;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check("wrong1_pulse", int'(wrong), 1);
    check("wrong1_tries", int'(tries_left), 1);
    check("wrong1_outs", outs(), V_INPUT);
    step();
    check("wrong_one_cycle", int'(wrong), 0);
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check("wrong2_lose", outs(), V_LOSE);
    check("wrong2_no_pulse", int'(wrong), 0);
    repeat (7) step();
    check("lose_hold", outs(), V_LOSE);
    step();
    check("lose_to_idle", outs(), V_IDLE);
    check("lose_rearm", int'(rearm), 1);

    // timeout -> LOSE exactly 20 cycles after INPUT entry
    play_to_input(exp_code);
    repeat (19) step();
    check("to_still_input", outs(), V_INPUT);
    check("to_last_sec", int'(sec_left), 1);
    step();
    check("to_lose", outs(), V_LOSE);
    repeat (8) step();
    check("to_back_idle", outs(), V_IDLE);

    // correct code on the timeout cycle wins
    play_to_input(exp_code);
    repeat (19) step();
    code_in = exp_code;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check("to_correct_win", outs(), V_WIN);
    repeat (8) step();
    check("to_win_idle", outs(), V_IDLE);

    // code_valid in IDLE ignored
    code_in = code_out;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
    check("idle_ignores_code", outs(), V_IDLE);

    // en dropped mid-INPUT aborts to OFF
    play_to_input(exp_code);
    check("abort_pre", outs(), V_INPUT);
    en = 1'b0;
    step();
    check("abort_outs", outs(), V_OFF);
    check("abort_code", int'(code_out), 0);
    check("abort_sec", int'(sec_left), 0);
    check("abort_tries", int'(tries_left), 0);
    check("abort_pulses", int'({wrong, rearm}), 0);
    en = 1'b1;
    step();
    check("reenable_idle", outs(), V_IDLE);

    // LFSR: nonzero, matches reference, period 31
    lfsr_first = dut.lfsr;
    for (int i = 1; i <= 31; i++) begin
      step();
      check("lfsr_model", int'(dut.lfsr), int'(lfsr_m));
      check("lfsr_nonzero", int'(dut.lfsr != 5'd0), 1);
      check("lfsr_period", int'(dut.lfsr == lfsr_first), (i == 31) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
